// File: rtl/segment_7.sv
// segment_7: registered 3-bit binary to seven-segment decoder.
// Outputs seg_a..seg_g carry one cycle of latency and are forced dark by an
// asynchronous active-low reset. COMMON_ANODE selects output polarity.
// Optional feature: define SEGMENT_7_LAMP_TEST_EN to add the lamp_test input,
// which lights every segment and overrides blank and binary.
module segment_7 #(
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] binary,
   input  logic       blank,
`ifdef SEGMENT_7_LAMP_TEST_EN
   input  logic       lamp_test,
`endif
   output logic       seg_a,
   output logic       seg_b,
   output logic       seg_c,
   output logic       seg_d,
   output logic       seg_e,
   output logic       seg_f,
   output logic       seg_g
);

   // Lit-pattern bit order is {a,b,c,d,e,f,g}; 1 means the segment is lit.
   localparam logic [6:0] LIT_NONE = 7'b000_0000;
   localparam logic [6:0] LIT_ALL  = 7'b111_1111;

   // Common-anode displays light a segment by pulling it low, so the
   // physical drive is the lit-pattern inverted bit by bit.
   localparam logic [6:0] POLARITY_MASK = {7{COMMON_ANODE}};

   logic [6:0] digit_lit;
   logic [6:0] lit_d;
   logic [6:0] lit_q;

   // Decode the binary value into its lit-pattern; every code is a digit.
   always_comb begin
      // NOTE: assign a default first so no path through the block leaves the
      // signal unassigned, which would infer a latch.
      digit_lit = LIT_NONE;
      case (binary)
         3'd0: digit_lit = 7'b111_1110;
         3'd1: digit_lit = 7'b011_0000;
         3'd2: digit_lit = 7'b110_1101;
         3'd3: digit_lit = 7'b111_1001;
         3'd4: digit_lit = 7'b011_0011;
         3'd5: digit_lit = 7'b101_1011;
         3'd6: digit_lit = 7'b101_1111;
         3'd7: digit_lit = 7'b111_0000;
         default: digit_lit = LIT_NONE;
      endcase
   end

   // Select the next lit-pattern; later assignments take priority
   // (lamp test over blank over the decoded digit).
   always_comb begin
      lit_d = digit_lit;
      if (blank) begin
         lit_d = LIT_NONE;
      end
`ifdef SEGMENT_7_LAMP_TEST_EN
      if (lamp_test) begin
         lit_d = LIT_ALL;
      end
`endif
   end

   // Register the lit-pattern; reset blanks the display without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples its inputs from before the edge.
      if (!rst_n) begin
         lit_q <= LIT_NONE;
      end else begin
         lit_q <= lit_d;
      end
   end

   // Apply output polarity; the mask is a constant, so seg_* still depend
   // only on the register and never directly on the inputs.
   assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = lit_q ^ POLARITY_MASK;

`ifndef SEGMENT_7_LAMP_TEST_EN
   // LIT_ALL is only consumed by the lamp-test path.
   logic unused_lit_all;
   assign unused_lit_all = ^LIT_ALL;
`endif

endmodule

// File: tb/tb_segment_7.sv
// tb_segment_7: directed self-checking bench for segment_7.
// Two instances share all inputs: dut_cc (COMMON_ANODE=0) and dut_ca
// (COMMON_ANODE=1), so every scenario checks both output polarities.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge, or mid-cycle for the asynchronous-reset and hold checks.
module tb_segment_7;

   logic       clk;
   logic       rst_n;
   logic [2:0] binary;
   logic       blank;
   logic       lamp_test;

   logic ca_a, ca_b, ca_c, ca_d, ca_e, ca_f, ca_g;
   logic cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g;
   logic [6:0] seg_cc;
   logic [6:0] seg_ca;

   int checks;
   int errors;

   logic [6:0] exp_tab [8];

   segment_7 #(.COMMON_ANODE(1'b0)) dut_cc (
      .clk       (clk),
      .rst_n     (rst_n),
      .binary    (binary),
      .blank     (blank),
`ifdef SEGMENT_7_LAMP_TEST_EN
      .lamp_test (lamp_test),
`endif
      .seg_a     (cc_a),
      .seg_b     (cc_b),
      .seg_c     (cc_c),
      .seg_d     (cc_d),
      .seg_e     (cc_e),
      .seg_f     (cc_f),
      .seg_g     (cc_g)
   );

   segment_7 #(.COMMON_ANODE(1'b1)) dut_ca (
      .clk       (clk),
      .rst_n     (rst_n),
      .binary    (binary),
      .blank     (blank),
`ifdef SEGMENT_7_LAMP_TEST_EN
      .lamp_test (lamp_test),
`endif
      .seg_a     (ca_a),
      .seg_b     (ca_b),
      .seg_c     (ca_c),
      .seg_d     (ca_d),
      .seg_e     (ca_e),
      .seg_f     (ca_f),
      .seg_g     (ca_g)
   );

   assign seg_cc = {cc_a, cc_b, cc_c, cc_d, cc_e, cc_f, cc_g};
   assign seg_ca = {ca_a, ca_b, ca_c, ca_d, ca_e, ca_f, ca_g};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reset asserted before any clock edge must blank both polarities at once
   // and keep them blank across edges.
   task automatic test_reset();
      rst_n     = 1'b0;
      binary    = 3'b011;
      blank     = 1'b0;
      lamp_test = 1'b0;
      #1;
      checks++;
      if (seg_cc !== 7'b000_0000) begin
         errors++;
         $display("FAIL reset_async_cc: got %b expected %b", seg_cc, 7'b000_0000);
      end
      checks++;
      if (seg_ca !== 7'b111_1111) begin
         errors++;
         $display("FAIL reset_async_ca: got %b expected %b", seg_ca, 7'b111_1111);
      end
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b000_0000) begin
         errors++;
         $display("FAIL reset_held_cc: got %b expected %b", seg_cc, 7'b000_0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Every code on successive edges, each visible one cycle after its edge.
   task automatic test_sweep();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         binary = 3'(i);
         @(posedge clk);
         #1;
         checks++;
         if (seg_cc !== exp_tab[i]) begin
            errors++;
            $display("FAIL sweep_cc[%0d]: got %b expected %b", i, seg_cc, exp_tab[i]);
         end
         checks++;
         if (seg_ca !== ~exp_tab[i]) begin
            errors++;
            $display("FAIL sweep_ca[%0d]: got %b expected %b", i, seg_ca, ~exp_tab[i]);
         end
      end
   endtask

   // Blank overrides the digit; releasing it shows the digit on the next edge.
   task automatic test_blank();
      @(negedge clk);
      binary = 3'b101;
      blank  = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b000_0000) begin
         errors++;
         $display("FAIL blank_on_cc: got %b expected %b", seg_cc, 7'b000_0000);
      end
      checks++;
      if (seg_ca !== 7'b111_1111) begin
         errors++;
         $display("FAIL blank_on_ca: got %b expected %b", seg_ca, 7'b111_1111);
      end
      @(negedge clk);
      blank = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b101_1011) begin
         errors++;
         $display("FAIL blank_off_cc: got %b expected %b", seg_cc, 7'b101_1011);
      end
   endtask

   // Common-anode drive for digit 1 is the inverse of its lit-pattern.
   task automatic test_polarity();
      @(negedge clk);
      binary = 3'b001;
      @(posedge clk);
      #1;
      checks++;
      if (seg_ca !== 7'b100_1111) begin
         errors++;
         $display("FAIL polarity_ca: got %b expected %b", seg_ca, 7'b100_1111);
      end
      checks++;
      if (seg_cc !== 7'b011_0000) begin
         errors++;
         $display("FAIL polarity_cc: got %b expected %b", seg_cc, 7'b011_0000);
      end
   endtask

   // Inputs changed between edges must not reach the outputs before the
   // next edge; identical inputs over consecutive edges keep outputs steady.
   task automatic test_stability();
      @(negedge clk);
      binary = 3'b010;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b110_1101) begin
         errors++;
         $display("FAIL stable_load: got %b expected %b", seg_cc, 7'b110_1101);
      end
      #2;
      binary = 3'b101;
      #1;
      checks++;
      if (seg_cc !== 7'b110_1101) begin
         errors++;
         $display("FAIL stable_midcycle: got %b expected %b", seg_cc, 7'b110_1101);
      end
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b101_1011) begin
         errors++;
         $display("FAIL stable_next_edge: got %b expected %b", seg_cc, 7'b101_1011);
      end
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b101_1011) begin
         errors++;
         $display("FAIL stable_repeat: got %b expected %b", seg_cc, 7'b101_1011);
      end
   endtask

   // Reset mid-cycle must blank a shown digit immediately, then the first
   // edge after release loads the inputs present at that edge.
   task automatic test_reset_mid();
      @(negedge clk);
      binary = 3'b110;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b101_1111) begin
         errors++;
         $display("FAIL mid_before: got %b expected %b", seg_cc, 7'b101_1111);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (seg_cc !== 7'b000_0000) begin
         errors++;
         $display("FAIL mid_reset_cc: got %b expected %b", seg_cc, 7'b000_0000);
      end
      checks++;
      if (seg_ca !== 7'b111_1111) begin
         errors++;
         $display("FAIL mid_reset_ca: got %b expected %b", seg_ca, 7'b111_1111);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      binary = 3'b100;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b011_0011) begin
         errors++;
         $display("FAIL release_first_edge: got %b expected %b", seg_cc, 7'b011_0011);
      end
   endtask

`ifdef SEGMENT_7_LAMP_TEST_EN
   // Lamp test overrides blank and the digit; dropping both shows the digit.
   task automatic test_lamp_test();
      @(negedge clk);
      lamp_test = 1'b1;
      blank     = 1'b1;
      binary    = 3'b000;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b111_1111) begin
         errors++;
         $display("FAIL lamp_on_cc: got %b expected %b", seg_cc, 7'b111_1111);
      end
      checks++;
      if (seg_ca !== 7'b000_0000) begin
         errors++;
         $display("FAIL lamp_on_ca: got %b expected %b", seg_ca, 7'b000_0000);
      end
      @(negedge clk);
      lamp_test = 1'b0;
      blank     = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (seg_cc !== 7'b111_1110) begin
         errors++;
         $display("FAIL lamp_off_cc: got %b expected %b", seg_cc, 7'b111_1110);
      end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      exp_tab[0] = 7'b111_1110;
      exp_tab[1] = 7'b011_0000;
      exp_tab[2] = 7'b110_1101;
      exp_tab[3] = 7'b111_1001;
      exp_tab[4] = 7'b011_0011;
      exp_tab[5] = 7'b101_1011;
      exp_tab[6] = 7'b101_1111;
      exp_tab[7] = 7'b111_0000;

      test_reset();
      test_sweep();
      test_blank();
      test_polarity();
      test_stability();
      test_reset_mid();
`ifdef SEGMENT_7_LAMP_TEST_EN
      test_lamp_test();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/segment_7.md
SEGMENT_7 -- requirements
Module: segment_7

Interface
REQ-001 SHALL have parameter COMMON_ANODE, default 0, meaning output polarity: 0 = segment lit at logic 1; 1 = segment lit at logic 0.
REQ-002 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port binary  input  3  unsigned value 0-7 to display.
REQ-005 SHALL have port blank  input  1  1 = all segments dark.
REQ-006 SHALL have ports seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g  output  1 each  registered segment drives, standard a-g naming (a top, clockwise, g middle).
REQ-007 SHALL have port lamp_test  input  1  1 = all segments lit; present only when SEGMENT_7_LAMP_TEST_EN is defined.

Function
REQ-008 SHALL decode binary into a lit-pattern abcdefg (1 = lit) per the table below.
REQ-009 Decode table: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
REQ-010 All 8 input codes SHALL be valid; no illegal or default-blank case exists.
REQ-011 Outputs SHALL be registered: value sampled at rising edge N appears on seg_* immediately after edge N (1-cycle latency), held stable until the next edge.
REQ-012 Priority per edge SHALL be: lamp_test (if compiled) > blank > decode.
REQ-013 blank=1 SHALL give lit-pattern 0000000 irrespective of binary.
REQ-014 Physical output SHALL equal lit-pattern when COMMON_ANODE=0, bitwise inverse when COMMON_ANODE=1.
REQ-015 Input changes between edges SHALL NOT affect outputs (no combinational path from inputs to seg_*).
REQ-016 Consecutive identical inputs SHALL keep outputs unchanged (no glitch, no toggling).

Reset
REQ-017 rst_n=0 SHALL immediately, without clk, force lit-pattern 0000000 (all dark: 0 if COMMON_ANODE=0, 1 if COMMON_ANODE=1).
REQ-018 Outputs SHALL stay dark while rst_n=0, regardless of clk or inputs.
REQ-019 After rst_n deasserts, the first rising edge SHALL load the decoded value of the inputs present at that edge.
REQ-020 Reset asserted mid-operation SHALL override any displayed digit at once.

Configuration
REQ-021 Macro SEGMENT_7_LAMP_TEST_EN: when defined, port lamp_test exists and lamp_test=1 at an edge registers lit-pattern 1111111, overriding blank and binary; reset still forces dark.
REQ-022 When SEGMENT_7_LAMP_TEST_EN is undefined, port lamp_test SHALL be absent and behaviour is REQ-008..REQ-020 only.

Verification
REQ-023 Reset: rst_n=0 with binary=3'b011 -> seg_a..seg_g=0000000 without any clk edge (COMMON_ANODE=0).
REQ-024 Sweep: release reset, apply binary 000,001,010,011,100,101,110,111 on successive edges -> seg_a..g = 1111110,0110000,1101101,1111001,0110011,1011011,1011111,1110000, each one cycle after its edge.
REQ-025 Blank: binary=3'b101, blank=1 -> 0000000; blank=0 next edge -> 1011011.
REQ-026 Polarity: COMMON_ANODE=1, binary=3'b001 -> seg_a..g=1001111; during reset -> 1111111.
REQ-027 Lamp test (macro defined): lamp_test=1, blank=1, binary=3'b000 -> 1111111; lamp_test=0, blank=0 -> 1111110.
REQ-028 Stability: change binary 010->101 midway between edges -> outputs hold 1101101 until next rising edge, then 1011011.
